// File: rtl/reaction_test_sequencer.sv
// Reaction-time tester: a start pulse arms a fixed delay, then the LED lights
// and a BCD counter (0.1 ms resolution) runs until press or 999.9 ms timeout.
// The best valid time since reset is kept in best_bcd.
module reaction_test_sequencer #(
  parameter int unsigned TICK_DIV    = 10000,
  parameter int unsigned DELAY_TICKS = 10000,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        start,
  input  logic        press,
  output logic        led,
  output logic [15:0] time_bcd,
  output logic [15:0] best_bcd,
  output logic        busy,
  output logic        done,
  output logic        false_start,
  output logic        timeout
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_MEASURE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_start_sync;
  logic [2:0]      r_press_sync;
  logic            r_auto;
  logic [PW-1:0]   r_presc;
  logic [DW-1:0]   r_delay;
  logic [15:0]     r_time;
  logic [15:0]     r_best;
  logic            r_false_start;
  logic            r_timeout;

  logic            w_start_p;
  logic            w_press_p;
  logic            w_tick;
  logic            w_enter_wait;
  logic [15:0]     w_time_inc;
  logic [15:0]     w_time_fin;
  logic            w_carry;

  // Two-flop synchronisers plus a history flop for rising-edge detection
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_start_sync <= '0;
      r_press_sync <= '0;
    end else begin
      r_start_sync <= {r_start_sync[1:0], start};
      r_press_sync <= {r_press_sync[1:0], press};
    end
  end

  assign w_start_p = r_start_sync[1] & ~r_start_sync[2];
  assign w_press_p = r_press_sync[1] & ~r_press_sync[2];
  assign w_tick    = (r_presc == PW'(TICK_DIV - 1));

  // One-shot that launches the first trial on the edge after reset release
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) r_auto <= AUTO_START;
    else        r_auto <= 1'b0;
  end

  // State register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a press on the final delay tick still counts as a false start
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_p || r_auto) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_press_p)                                          w_next = S_FAULT;
        else if (w_tick && (r_delay == DW'(DELAY_TICKS - 1)))   w_next = S_MEASURE;
      end
      S_MEASURE: begin
        if (w_tick && (r_time == 16'h9999)) w_next = S_FAULT;
        else if (w_press_p)                 w_next = S_DONE;
      end
      S_DONE, S_FAULT: begin
        if (w_start_p) w_next = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_wait = (w_next == S_WAIT) && (r_state != S_WAIT);

  // Decimal increment of the four-digit time counter
  always_comb begin
    w_time_inc = r_time;
    w_carry    = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_time[4*i +: 4] == 4'd9) begin
          w_time_inc[4*i +: 4] = 4'd0;
        end else begin
          w_time_inc[4*i +: 4] = r_time[4*i +: 4] + 4'd1;
          w_carry              = 1'b0;
        end
      end
    end
  end

  // A tick coinciding with the press is counted before the time freezes
  assign w_time_fin = w_tick ? w_time_inc : r_time;

  // Prescaler, delay counter, time/best registers and sticky fault flags
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_presc       <= '0;
      r_delay       <= '0;
      r_time        <= '0;
      r_best        <= 16'h9999;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else if (w_enter_wait) begin
      r_presc       <= '0;
      r_delay       <= '0;
      r_time        <= '0;
      r_false_start <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          r_presc <= w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) r_delay <= r_delay + DW'(1);
          if (w_next == S_FAULT) r_false_start <= 1'b1;
        end
        S_MEASURE: begin
          r_presc <= w_tick ? '0 : r_presc + PW'(1);
          if (w_next == S_FAULT) begin
            r_timeout <= 1'b1;
          end else begin
            r_time <= w_time_fin;
            if ((w_next == S_DONE) && (w_time_fin < r_best)) r_best <= w_time_fin;
          end
        end
        default: begin
          r_presc <= '0;
          r_delay <= '0;
        end
      endcase
    end
  end

  assign led         = (r_state == S_MEASURE);
  assign busy        = (r_state == S_WAIT) || (r_state == S_MEASURE);
  assign done        = (r_state == S_DONE);
  assign false_start = r_false_start;
  assign timeout     = r_timeout;
  assign time_bcd    = r_time;
  assign best_bcd    = r_best;

endmodule

// File: tb/tb_reaction_test_sequencer.sv
// Directed bench for reaction_test_sequencer with TICK_DIV=4, DELAY_TICKS=10.
// A second instance with AUTO_START=1 covers the launch on reset release.
module tb_reaction_test_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        press;
  logic        led;
  logic [15:0] time_bcd;
  logic [15:0] best_bcd;
  logic        busy;
  logic        done;
  logic        false_start;
  logic        timeout;

  logic        a_led;
  logic [15:0] a_time_bcd;
  logic [15:0] a_best_bcd;
  logic        a_busy;
  logic        a_done;
  logic        a_false_start;
  logic        a_timeout;

  int n_checks;
  int n_errors;

  reaction_test_sequencer #(
    .TICK_DIV   (4),
    .DELAY_TICKS(10),
    .AUTO_START (1'b0)
  ) u_dut (
    .sysclk     (clk),
    .reset      (rst_n),
    .start      (start),
    .press      (press),
    .led        (led),
    .time_bcd   (time_bcd),
    .best_bcd   (best_bcd),
    .busy       (busy),
    .done       (done),
    .false_start(false_start),
    .timeout    (timeout)
  );

  reaction_test_sequencer #(
    .TICK_DIV   (4),
    .DELAY_TICKS(10),
    .AUTO_START (1'b1)
  ) u_auto (
    .sysclk     (clk),
    .reset      (rst_n),
    .start      (1'b0),
    .press      (1'b0),
    .led        (a_led),
    .time_bcd   (a_time_bcd),
    .best_bcd   (a_best_bcd),
    .busy       (a_busy),
    .done       (a_done),
    .false_start(a_false_start),
    .timeout    (a_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a trial from a non-busy state and run until the LED is lit (M0 + 1 time unit)
  task automatic to_measure(input string tag);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    chk({tag, "_busy_pre"}, {15'd0, busy}, 16'd0);
    step(1);
    chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
    chk({tag, "_time_clr"}, time_bcd, 16'h0000);
    step(39);
    chk({tag, "_led_pre"}, {15'd0, led}, 16'd0);
    step(1);
    chk({tag, "_led"}, {15'd0, led}, 16'd1);
  endtask

  // Raise press after edge M0+n; the pulse acts on edge M0+n+3
  task automatic press_after(input int n);
    step(n);
    press = 1'b1;
    step(3);
    press = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    press    = 1'b0;

    // Reset values
    step(2);
    chk("rst_time", time_bcd, 16'h0000);
    chk("rst_best", best_bcd, 16'h9999);
    chk("rst_flags", {10'd0, led, busy, done, false_start, timeout, 1'b0}, 16'd0);
    chk("rst_auto_busy", {15'd0, a_busy}, 16'd0);

    // Release: auto instance launches on first edge, manual one stays idle
    rst_n = 1'b1;
    step(1);
    chk("auto_busy", {15'd0, a_busy}, 16'd1);
    chk("manual_idle", {15'd0, busy}, 16'd0);
    step(5);
    chk("manual_idle2", {15'd0, busy}, 16'd0);

    // Trial at 37 ticks
    to_measure("t37");
    press_after(147);
    chk("t37_done", {15'd0, done}, 16'd1);
    chk("t37_time", time_bcd, 16'h0037);
    chk("t37_best", best_bcd, 16'h0037);
    chk("t37_led", {15'd0, led}, 16'd0);

    // Press while DONE is ignored
    press_after(2);
    step(4);
    chk("done_press_ign", {15'd0, done}, 16'd1);
    chk("done_press_time", time_bcd, 16'h0037);

    // Trial at 25 ticks improves best
    to_measure("t25");
    press_after(97);
    chk("t25_time", time_bcd, 16'h0025);
    chk("t25_best", best_bcd, 16'h0025);

    // Trial at 50 ticks leaves best alone
    to_measure("t50");
    press_after(197);
    chk("t50_time", time_bcd, 16'h0050);
    chk("t50_best", best_bcd, 16'h0025);

    // Press pulse coincides with the tick leaving 0x0041
    to_measure("tco");
    press_after(165);
    chk("tco_done", {15'd0, done}, 16'd1);
    chk("tco_time", time_bcd, 16'h0042);
    chk("tco_best", best_bcd, 16'h0025);

    // False start: press acts 13 cycles into WAIT
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    chk("fs_busy", {15'd0, busy}, 16'd1);
    press_after(10);
    chk("fs_flag", {15'd0, false_start}, 16'd1);
    chk("fs_busy_off", {15'd0, busy}, 16'd0);
    chk("fs_time", time_bcd, 16'h0000);
    step(40);
    chk("fs_led", {15'd0, led}, 16'd0);
    chk("fs_best", best_bcd, 16'h0025);

    // Timeout run; the new start also clears false_start
    to_measure("tmo");
    chk("tmo_fs_clr", {15'd0, false_start}, 16'd0);
    step(36);
    chk("tmo_0009", time_bcd, 16'h0009);
    step(4);
    chk("tmo_0010", time_bcd, 16'h0010);
    step(356);
    chk("tmo_0099", time_bcd, 16'h0099);
    step(4);
    chk("tmo_0100", time_bcd, 16'h0100);
    step(39596);
    chk("tmo_9999", time_bcd, 16'h9999);
    chk("tmo_pre", {14'd0, busy, timeout}, 16'b10);
    step(4);
    chk("tmo_flag", {15'd0, timeout}, 16'd1);
    chk("tmo_led", {15'd0, led}, 16'd0);
    chk("tmo_hold", time_bcd, 16'h9999);
    chk("tmo_best", best_bcd, 16'h0025);

    // Next trial clears timeout; reset mid-MEASURE aborts
    to_measure("rmid");
    chk("rmid_to_clr", {15'd0, timeout}, 16'd0);
    step(20);
    chk("rmid_time", time_bcd, 16'h0005);
    rst_n = 1'b0;
    #1;
    chk("rmid_time_rst", time_bcd, 16'h0000);
    chk("rmid_best_rst", best_bcd, 16'h9999);
    chk("rmid_flags", {10'd0, led, busy, done, false_start, timeout, 1'b0}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reaction_test_sequencer.md
REACTION_TEST_SEQUENCER -- requirements
Module: reaction_test_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 10000, is the number of sysclk cycles per 0.1 ms measurement tick.
REQ-002 Parameter DELAY_TICKS, default 10000, is the LED-on delay in ticks (1 s).
REQ-003 Parameter AUTO_START, default 1, means a trial starts automatically on reset release when set to 1.
REQ-004 sysclk  in  1  the only clock; all flops clock on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  raw "new trial" button, asynchronous.
REQ-007 press  in  1  raw reaction button, asynchronous.
REQ-008 led  out  1  stimulus LED.
REQ-009 time_bcd  out  16  last/current reaction time as 4 BCD digits, [3:0] = 0.1 ms digit, range 000.0-999.9 ms.
REQ-010 best_bcd  out  16  best valid time since reset, same format.
REQ-011 busy  out  1  trial in progress.
REQ-012 done  out  1  valid measurement held.
REQ-013 false_start  out  1  press occurred before the LED lit.
REQ-014 timeout  out  1  no press before 999.9 ms.

Function
REQ-015 start and press SHALL each pass through a 2-flop synchroniser plus rising-edge detector, so a pin edge produces a one-cycle internal pulse 3 sysclk cycles later.
REQ-016 A prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on TICK_DIV-1; it SHALL clear on every entry to WAIT.
REQ-017 The FSM states SHALL be IDLE, WAIT, MEASURE, DONE and FAULT.
REQ-018 In IDLE, DONE or FAULT, a start pulse SHALL enter WAIT and clear time_bcd, done, false_start, timeout, the prescaler and the delay counter.
REQ-019 In WAIT and MEASURE, start pulses SHALL be ignored.
REQ-020 In WAIT, after DELAY_TICKS ticks the FSM SHALL enter MEASURE with time_bcd = 0x0000.
REQ-021 In WAIT, a press pulse SHALL enter FAULT with false_start=1; if it coincides with the final delay tick, the press wins.
REQ-022 In MEASURE, each tick SHALL increment time_bcd as a decimal counter (a digit at 9 wraps to 0 with carry).
REQ-023 In MEASURE, a press pulse SHALL enter DONE and freeze time_bcd; a tick in the same cycle is counted first.
REQ-024 In MEASURE, a tick with time_bcd = 0x9999 SHALL enter FAULT with timeout=1 and hold time_bcd at 0x9999.
REQ-025 On entry to DONE, best_bcd SHALL be loaded with the final time when that time is less than best_bcd, visible no later than 1 cycle after done rises.
REQ-026 FAULT trials SHALL never update best_bcd.
REQ-027 led SHALL be 1 only in MEASURE.
REQ-028 busy SHALL be 1 in WAIT or MEASURE.
REQ-029 done SHALL be 1 only in DONE.
REQ-030 false_start and timeout SHALL hold until the next start pulse or reset.
REQ-031 Press pulses in IDLE, DONE or FAULT SHALL be ignored.

Reset
REQ-032 reset=0 SHALL immediately force: FSM to IDLE, led=0, busy=0, done=0, false_start=0, timeout=0, time_bcd=0x0000, best_bcd=0x9999, and clear all counters and synchronisers.
REQ-033 On reset release with AUTO_START=1, the FSM SHALL enter WAIT on the first sysclk edge; with AUTO_START=0 it SHALL stay in IDLE.
REQ-034 Reset asserted mid-trial SHALL abort the trial with no best_bcd update.

Verification (TICK_DIV=4, DELAY_TICKS=10)
REQ-035 Scenario 1: AUTO_START=0, release reset, pulse start -> busy=1 after 3 cycles; led rises exactly 40 cycles after WAIT entry.
REQ-036 Scenario 2: press after 37 ticks -> time_bcd=0x0037, done=1, best_bcd=0x0037; next trial at 25 ticks -> best_bcd=0x0025; next at 50 ticks -> best_bcd stays 0x0025.
REQ-037 Scenario 3: press during WAIT -> false_start=1, led never rises, time_bcd=0x0000, best_bcd unchanged.
REQ-038 Scenario 4: no press -> time_bcd steps through 0x0009->0x0010 and 0x0099->0x0100, reaches 0x9999; the next tick gives timeout=1, led=0.
REQ-039 Scenario 5: press edge aligned so its pulse coincides with a tick at count 0x0041 -> final time_bcd=0x0042.
REQ-040 Scenario 6: reset low mid-MEASURE -> all outputs at reset values within the same cycle, best_bcd=0x9999.
